serial_addsub: RTL and testbench

Parametrised, multi-cycle add/subtract unit for the ALU. It processes `DIGIT` bits per clock through a ripple slice built from `FullAdder` cells, carrying the digit carry in a register between cycles. It produces a `WIDTH`-bit result plus carry, signed-overflow and zero flags. Operands enter and results leave through valid/ready handshakes, so the ALU top can stall on either side.

---
 rtl/alu_pkg.sv | 18 +
 rtl/serial_addsub_if.sv | 32 +++
 rtl/FullAdder.sv | 20 ++
 rtl/addsub_digit.sv | 37 +++
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | alu_pkg                                                        |
// | Shared ALU opcode constants and serial add/sub state encoding. |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_SUB = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_addsub_if                                               |
// | Operand/result handshake bundle for the serial add/sub unit.   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
interface serial_addsub_if #(
  parameter int WIDTH = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] X;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, sel, A, B, out_ready,
    output in_ready, out_valid, X, cout, ovf, zero
  );

  modport master (
    output in_valid, sel, A, B, out_ready,
    input  in_ready, out_valid, X, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
// +----------------------------------------------------------------+
// | FullAdder                                                      |
// | Single-bit full adder cell.                                    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module FullAdder (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);
  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);
endmodule
`default_nettype wire

// File: rtl/addsub_digit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | addsub_digit                                                   |
// | Combinational DIGIT-bit ripple slice of FullAdder cells.       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  wire logic [DIGIT-1:0] a,
  input  wire logic [DIGIT-1:0] b,
  input  wire logic             cin,
  output logic      [DIGIT-1:0] s,
  output logic                  cout,
  output logic                  c_msb_in
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      FullAdder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (w_c[i]),
        .s    (s[i]),
        .cout (w_c[i+1])
      );
    end
  endgenerate

  assign cout     = w_c[DIGIT];
  // Carry into the top bit; only meaningful on the most significant digit.
  assign c_msb_in = w_c[DIGIT-1];
endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_addsub                                                  |
// | Digit-serial add/subtract with carry, overflow and zero flags. |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  serial_addsub_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] w_x_next;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum;
  logic             w_dig_cout;
  logic             w_dig_c_msb;
  logic             w_sub;
  logic             w_accept;
  logic             w_last;

  assign w_sub    = (bus.sel == OP_SUB);
  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == C_LAST);

  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int d = 0; d < N; d++) begin
      if (r_cnt == CNT_W'(d)) begin
        w_a_dig = r_a[d*DIGIT +: DIGIT];
        w_b_dig = r_b[d*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    w_x_next = r_x;
    for (int d = 0; d < N; d++) begin
      if (r_cnt == CNT_W'(d)) begin
        w_x_next[d*DIGIT +: DIGIT] = w_sum;
      end
    end
  end

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a        (w_a_dig),
    .b        (w_b_dig),
    .cin      (r_carry),
    .s        (w_sum),
    .cout     (w_dig_cout),
    .c_msb_in (w_dig_c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= w_sub ? ~bus.B : bus.B;
      r_carry <= w_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_x     <= w_x_next;
      r_carry <= w_dig_cout;
      if (w_last) begin
        r_cout <= w_dig_cout;
        r_ovf  <= w_dig_cout ^ w_dig_c_msb;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.X         = r_x;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = (r_x == '0);
endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_serial_addsub                                               |
// | Randomised + directed bench against an arithmetic model.       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_serial_addsub;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   fails;

  serial_addsub_if #(.WIDTH(6)) b6 ();
  serial_addsub_if #(.WIDTH(8)) b8 ();

  serial_addsub #(.WIDTH(6), .DIGIT(2)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [31:0] x;
    logic        c;
    logic        o;
    logic        z;
  } obs_t;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input int a, input int b, input bit sub,
                                output int x, output bit c, output bit o);
    int m, sa, sb, r;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      x = (a - b + m) % m;
      c = (a >= b);
      r = sa - sb;
    end else begin
      x = (a + b) % m;
      c = ((a + b) >= m);
      r = sa + sb;
    end
    o = (r < -(m / 2)) || (r > (m / 2 - 1));
  endfunction

  function automatic obs_t sample(int w);
    obs_t r;
    if (w == 8) begin
      r.rdy = b8.in_ready; r.vld = b8.out_valid; r.x = 32'(b8.X);
      r.c = b8.cout; r.o = b8.ovf; r.z = b8.zero;
    end else begin
      r.rdy = b6.in_ready; r.vld = b6.out_valid; r.x = 32'(b6.X);
      r.c = b6.cout; r.o = b6.ovf; r.z = b6.zero;
    end
    return r;
  endfunction

  function automatic logic [3:0] add_sel();
    logic [3:0] s;
    s = 4'($urandom_range(0, 15));
    if (s == 4'b1011) s = 4'b0000;
    return s;
  endfunction

  task automatic drive_in(int w, bit v, int a, int b, logic [3:0] s);
    if (w == 8) begin
      b8.in_valid = v; b8.A = 8'(a); b8.B = 8'(b); b8.sel = s;
    end else begin
      b6.in_valid = v; b6.A = 6'(a); b6.B = 6'(b); b6.sel = s;
    end
  endtask

  task automatic set_out_ready(int w, bit r);
    if (w == 8) b8.out_ready = r;
    else        b6.out_ready = r;
  endtask

  task automatic scramble(int w);
    drive_in(w, 1'b0, int'($urandom), int'($urandom), 4'($urandom));
  endtask

  // Called #1 after the accept edge; counts edges until out_valid appears.
  task automatic wait_result(int w, int n, int ex, bit ec, bit eo);
    int   cyc;
    obs_t ob;
    cyc = 0;
    ob  = sample(w);
    while (!ob.vld && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      ob = sample(w);
    end
    check("latency", cyc, n);
    check("x", ob.x, ex);
    check("cout", 32'(ob.c), 32'(ec));
    check("ovf", 32'(ob.o), 32'(eo));
    check("zero", 32'(ob.z), 32'(ex == 0));
    check("rdy_busy", 32'(ob.rdy), 0);
  endtask

  task automatic handshake(int w);
    obs_t ob;
    set_out_ready(w, 1'b1);
    @(posedge clk); #1;
    set_out_ready(w, 1'b0);
    ob = sample(w);
    check("vld_after_hs", 32'(ob.vld), 0);
    check("rdy_after_hs", 32'(ob.rdy), 1);
  endtask

  task automatic run_op(int w, int a, int b, bit sub, int stall);
    int   ex, n;
    bit   ec, eo;
    obs_t ob;
    n = (w == 8) ? 2 : 3;
    model(w, a, b, sub, ex, ec, eo);
    drive_in(w, 1'b1, a, b, sub ? 4'b1011 : add_sel());
    check("rdy_idle", 32'(sample(w).rdy), 1);
    @(posedge clk); #1;
    scramble(w);
    wait_result(w, n, ex, ec, eo);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      ob = sample(w);
      check("hold_vld", 32'(ob.vld), 1);
      check("hold_x", ob.x, ex);
    end
    handshake(w);
  endtask

  initial begin
    int   ex;
    bit   ec, eo;
    obs_t ob;
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0;
    drive_in(6, 1'b0, 0, 0, 4'd0);
    drive_in(8, 1'b0, 0, 0, 4'd0);
    set_out_ready(6, 1'b0);
    set_out_ready(8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ob = sample(6);
    check("rst_rdy", 32'(ob.rdy), 1);
    check("rst_vld", 32'(ob.vld), 0);
    check("rst_x", ob.x, 0);
    check("rst_cout", 32'(ob.c), 0);
    check("rst_ovf", 32'(ob.o), 0);
    check("rst_zero", 32'(ob.z), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op(6, 20, 25, 1'b0, 0);
    run_op(6, 10, 3, 1'b1, 0);
    run_op(6, 5, 5, 1'b1, 1);
    run_op(6, 3, 10, 1'b1, 0);
    run_op(6, 63, 1, 1'b0, 0);

    // Stall in DONE while a new operand set is already offered.
    model(6, 12, 7, 1'b0, ex, ec, eo);
    drive_in(6, 1'b1, 12, 7, 4'd0);
    @(posedge clk); #1;
    scramble(6);
    wait_result(6, 3, ex, ec, eo);
    drive_in(6, 1'b1, 30, 9, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ob = sample(6);
      check("stall_rdy", 32'(ob.rdy), 0);
      check("stall_vld", 32'(ob.vld), 1);
      check("stall_x", ob.x, ex);
      check("stall_c", 32'(ob.c), 32'(ec));
    end
    handshake(6);
    @(posedge clk); #1;
    check("second_accept", 32'(sample(6).rdy), 0);
    scramble(6);
    model(6, 30, 9, 1'b1, ex, ec, eo);
    wait_result(6, 3, ex, ec, eo);
    handshake(6);

    // Reset during the second RUN cycle.
    drive_in(6, 1'b1, 40, 17, 4'd0);
    @(posedge clk); #1;
    scramble(6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ob = sample(6);
    check("abort_vld", 32'(ob.vld), 0);
    check("abort_rdy", 32'(ob.rdy), 1);
    check("abort_x", ob.x, 0);
    check("abort_zero", 32'(ob.z), 1);
    repeat (4) @(posedge clk);
    #1;
    check("abort_quiet", 32'(sample(6).vld), 0);
    run_op(6, 1, 1, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(6, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Wider configuration: 8-bit operands, 4-bit digits.
    run_op(8, 8'h80, 8'h01, 1'b1, 0);
    run_op(8, 8'h7F, 8'h01, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
